datapath: RTL
=============

# datapath

Execution datapath directly downstream of the instruction controller. It consumes the controller's per-cycle control word: data-memory address and write, register-file read/write addresses and enables, write-back select, and ALU operation. It holds the 16×16 register file, a 256×16 synchronous data memory and the ALU, and exposes their results for observation and bench checking.

## Interface

Parameters:
- `DW`, 16, data word width
- `RF_DEPTH`, 16, register count; address width is 4
- `DM_DEPTH`, 256, data-memory words; address width is 8

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge
- `Rst`  in  1  reset, asynchronous, active-low
- `D_Addr`  in  8  data-memory address
- `D_Wr`  in  1  data-memory write enable
- `RF_s`  in  1  write-back select: 1 = data-memory read data, 0 = ALU result
- `RF_W_en`  in  1  register-file write enable
- `RF_Ra_Addr`  in  4  read port A address
- `RF_Rb_Addr`  in  4  read port B address
- `RF_W_Addr`  in  4  write address
- `ALU_s0`  in  3  ALU operation
- `Ra_Data`  out  16  register file port A data (combinational)
- `Rb_Data`  out  16  register file port B data (combinational)
- `ALU_Out`  out  16  ALU result (combinational)
- `DMem_Q`  out  16  registered data-memory read data
- `W_Data`  out  16  selected write-back data (combinational)

## Operation

- **Register file.**
  - Two asynchronous read ports.
  - One synchronous write port: `RF[RF_W_Addr] <= W_Data` when `RF_W_en` = 1.
  - All registers are writable, including R0.
- **Write-back mux.** `W_Data = RF_s ? DMem_Q : ALU_Out`.
- **Data memory.**
  - Every edge: `DMem_Q <= mem[D_Addr]`.
  - When `D_Wr` = 1: `mem[D_Addr] <= Ra_Data`. Store data always comes from port A.
  - Same-edge read and write to the same address: `DMem_Q` gets the old contents (read-before-write).
- **ALU** (A = `Ra_Data`, B = `Rb_Data`, results truncated to 16 bits, two's complement):
  - 000: 0
  - 001: A+B
  - 010: A−B
  - 011: A (pass)
  - 100: A^B
  - 101: A|B
  - 110: A&B
  - 111: A+1
- **Register-file read during write.** A read of the address being written returns the old value until the edge, then the new value.
- **Reset.**
  - `Rst` low asynchronously clears all registers to 0 and `DMem_Q` to 0, and suppresses all writes.
  - Memory array contents are not reset.
  - Reset asserted mid-operation aborts any pending write on that edge.
  - Release is synchronised by the first rising edge with `Rst` high.
- **Out-of-range values.** Addresses cannot go out of range, because widths match the depths exactly.
- **Simultaneous writes.** `D_Wr` and `RF_W_en` together in one cycle are legal and independent.

## Timing

- Register-file write latency: 1 edge. The value is visible on `Ra_Data`/`Rb_Data` after the edge.
- ALU result: same cycle as its operands. `ALU_Out` → register file in 1 edge.
- Memory read latency: 1 cycle. `D_Addr` is presented in cycle N and `DMem_Q` is valid in cycle N+1.
  - A load therefore takes two controller cycles: address in N, then `RF_s`=1 and `RF_W_en`=1 in N+1.
  - `D_Addr` must be held in N+1, because `DMem_Q` re-samples on every edge.
- Memory write latency: 1 edge. A read of the same address issued in the following cycle returns the new data one cycle later.
- Reset values of outputs:
  - `Ra_Data`, `Rb_Data`, `DMem_Q` = 0.
  - `ALU_Out` = f(0,0): 0 for every op except 111, which gives 1.
  - `W_Data` follows its mux.

## Configuration

- `DATAPATH_FLAGS_EN` defined:
  - Adds outputs `Flag_Z`, `Flag_N`, `Flag_C` (1 bit each), held in a flag register.
  - The flag register updates on every edge where `RF_W_en`=1 and `RF_s`=0.
    - Z = (ALU result == 0).
    - N = bit 15 of the result.
    - C = carry-out for ops 001 and 111, borrow (A<B unsigned) for 010, and 0 for all other ops.
  - Flags reset to 0 and hold their value otherwise.
- Macro undefined: no flag ports, no flag register; behaviour is otherwise identical.

## Test plan

- **Reset.** Assert `Rst`=0 mid-cycle with `RF_W_en`=1 → `Ra_Data`, `Rb_Data` and `DMem_Q` go to 0 immediately, and no write occurs.
- **ALU write-back.** Load R1=0x0005 and R2=0x0003 via memory, then run `ALU_s0`=001 with W=R3 and `RF_s`=0 → R3=0x0008. Repeat with op 010 → 0x0002, and with 010 swapped (3−5) → 0xFFFE.
- **Store/load round trip.**
  - Store: R1=0x1234, `D_Addr`=0xA5, `D_Wr`=1.
  - Load: `D_Addr`=0xA5 for 2 cycles, `RF_s`=1, `RF_W_en`=1 in the second cycle, W=R7.
  - Expect R7=0x1234. In the first cycle `DMem_Q` is not yet 0x1234.
- **Read-before-write.** mem[0x10]=0x00FF; write 0xAAAA to 0x10 with the same address held → `DMem_Q`=0x00FF after that edge and 0xAAAA after the next.
- **RF write/read collision.** Set `RF_Ra_Addr`=`RF_W_Addr`=4 and write 0xBEEF over 0x0001 → `Ra_Data`=0x0001 before the edge and 0xBEEF after.
- **Flags** (with `DATAPATH_FLAGS_EN`):
  - 0xFFFF+0x0001 → result 0, Z=1, C=1, N=0.
  - 0x0001−0x0002 → 0xFFFF, N=1, C=1, Z=0.
  - A memory load with `RF_s`=1 leaves the flags unchanged.

Source files
------------

// File: rtl/datapath.sv
// Execution datapath: 16x16 register file, synchronous data memory, ALU and write-back mux.
// Optional ALU status flags are built when DATAPATH_FLAGS_EN is defined.
module datapath #(
    parameter int unsigned DW       = 16,
    parameter int unsigned RF_DEPTH = 16,
    parameter int unsigned DM_DEPTH = 256
) (
    input  logic                        Clk,
    input  logic                        Rst,
`ifdef DATAPATH_FLAGS_EN
    output logic                        Flag_Z,
    output logic                        Flag_N,
    output logic                        Flag_C,
`endif
    input  logic [$clog2(DM_DEPTH)-1:0] D_Addr,
    input  logic                        D_Wr,
    input  logic                        RF_s,
    input  logic                        RF_W_en,
    input  logic [$clog2(RF_DEPTH)-1:0] RF_Ra_Addr,
    input  logic [$clog2(RF_DEPTH)-1:0] RF_Rb_Addr,
    input  logic [$clog2(RF_DEPTH)-1:0] RF_W_Addr,
    input  logic [2:0]                  ALU_s0,
    output logic [DW-1:0]               Ra_Data,
    output logic [DW-1:0]               Rb_Data,
    output logic [DW-1:0]               ALU_Out,
    output logic [DW-1:0]               DMem_Q,
    output logic [DW-1:0]               W_Data
);

    logic [DW-1:0] rf_q [RF_DEPTH];
    logic [DW-1:0] mem_q [DM_DEPTH];
    logic [DW-1:0] dmem_q;
    logic [DW-1:0] alu_d;

    // Register file: two asynchronous read ports, one synchronous write port.
    assign Ra_Data = rf_q[RF_Ra_Addr];
    assign Rb_Data = rf_q[RF_Rb_Addr];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RF_W_en) begin
            rf_q[RF_W_Addr] <= W_Data;
        end
    end

    always_comb begin
        alu_d = '0;
        unique case (ALU_s0)
            3'b000: alu_d = '0;
            3'b001: alu_d = Ra_Data + Rb_Data;
            3'b010: alu_d = Ra_Data - Rb_Data;
            3'b011: alu_d = Ra_Data;
            3'b100: alu_d = Ra_Data ^ Rb_Data;
            3'b101: alu_d = Ra_Data | Rb_Data;
            3'b110: alu_d = Ra_Data & Rb_Data;
            3'b111: alu_d = Ra_Data + 1'b1;
            default: alu_d = '0;
        endcase
    end

    assign ALU_Out = alu_d;
    assign W_Data  = RF_s ? dmem_q : alu_d;

    // Array has no reset; Rst gates writes so an asserted reset aborts a pending store.
    always_ff @(posedge Clk) begin
        if (Rst && D_Wr) begin
            mem_q[D_Addr] <= Ra_Data;
        end
    end

    // Read port samples the pre-write contents, giving read-before-write on a collision.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            dmem_q <= '0;
        end else begin
            dmem_q <= mem_q[D_Addr];
        end
    end

    assign DMem_Q = dmem_q;

`ifdef DATAPATH_FLAGS_EN
    logic [2:0] flags_q;
    logic [2:0] flags_d;
    logic       carry;

    // Carry out of an unsigned add shows up as a wrapped sum smaller than an operand.
    always_comb begin
        carry = 1'b0;
        unique case (ALU_s0)
            3'b001:  carry = (alu_d < Ra_Data);
            3'b010:  carry = (Ra_Data < Rb_Data);
            3'b111:  carry = (Ra_Data == {DW{1'b1}});
            default: carry = 1'b0;
        endcase
        flags_d = flags_q;
        if (RF_W_en && !RF_s) begin
            flags_d = {(alu_d == '0), alu_d[DW-1], carry};
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flag_Z = flags_q[2];
    assign Flag_N = flags_q[1];
    assign Flag_C = flags_q[0];
`endif

endmodule
